data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised synchronous data memory for the MIPS datapath MEM stage. Serves LB/LBU/LH/LHU/LW
//  and SB/SH/SW with byte-lane enables, registered 1-cycle response, and alignment/range checks.
//  Clears all contents after reset via an init sequencer.
//  Replaces the combinational, word-only data memory with a clocked req/rsp slave.
// PARAMETERS
//  DEPTH          1024  number of 32-bit words; power of 2, >= 4
//  ADDR_W         32    request byte-address width
//  CLEAR_ON_RESET 1     1: zero every word after reset; 0: skip clear, contents undefined
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       synchronous, active-low reset
//  req_valid    in   1       request present this cycle
//  req_ready    out  1       block accepts requests (1 only in READY)
//  req_we       in   1       1 = store, 0 = load
//  req_size     in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1       loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-justified (SB uses [7:0], SH [15:0])
//  rsp_valid    out  1       one-cycle pulse, one per accepted request
//  rsp_rdata    out  32      extended load data; 0 for stores and errors
//  rsp_err      out  1       misaligned, out-of-range or illegal size
//  init_done    out  1       1 once clear finished (or immediately if CLEAR_ON_RESET=0)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_done=0,
//    clear counter=0, state<=CLEAR (CLEAR_ON_RESET=1) else READY.
//  - FSM: CLEAR: write 0 to word[cnt], cnt++ each cycle; at cnt==DEPTH-1 -> READY next cycle
//    (exactly DEPTH clear cycles). READY: req_ready=1, init_done=1; stays until reset.
//  - Reset asserted mid-CLEAR restarts clear from word 0. No other exit from READY.
//  - Accept = req_valid & req_ready. Requests while req_ready=0 are dropped: no write, no response.
//  - Word index = req_addr[log2(DEPTH)+1:2]. Little-endian lanes: byte k = bits [8k+7:8k],
//    k = req_addr[1:0].
//  - Error if: req_size==11; half with addr[0]=1; word with addr[1:0]!=0; addr >= 4*DEPTH.
//    Error request: memory unchanged, rsp_err=1, rsp_rdata=0.
//  - Store: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0}+1:0 with
//    wdata[15:0]; SW writes all 4 lanes. Unselected lanes preserved.
//  - Load: byte/half extracted from addressed lane(s), then sign- or zero-extended to 32 bits.
//    Word ignores req_unsigned.
//  - Latency: accept at edge N -> rsp_valid=1 during cycle N+1 (loads and stores alike).
//    Full throughput: one request per cycle.
//  - Memory updates at the accepting edge. Load accepted the cycle after a store to the same
//    word returns the new data. No same-cycle hazard (one request per cycle).
//  - rsp_rdata/rsp_err hold last value when rsp_valid=0. Only rsp_valid is a pulse.
// STRUCTURE
//  - Package dmem_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_ILL 2-bit constants, state encoding
//    ST_CLEAR/ST_READY, function for log2 of DEPTH.
//  - Sub-module dmem_align (combinational): {size, addr[1:0], wdata} -> 4-bit byte enable +
//    lane-shifted write word + misalign flag; {size, unsigned, addr[1:0], rword} -> extended load.
//  - Top holds FSM, clear counter, memory array, response registers.
// TESTING
//  1. Reset, DEPTH=1024: req_ready=0 for exactly 1024 cycles, then 1; LW 0x0FFC -> 0x00000000.
//  2. SW 0x10 <= 0x8899AABB; LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088;
//     LH 0x10 -> 0xFFFFAABB; LHU 0x12 -> 0x00008899.
//  3. SW 0x20 <= 0x11223344; SB 0x21 <= 0xEE; SH 0x22 <= 0x5566 back-to-back;
//     LW 0x20 next cycle -> 0x5566EE44, rsp_valid every cycle.
//  4. LW 0x22, LH 0x23, size=11, LW 0x1000 -> each rsp_err=1, rdata=0;
//     SW 0x22 <= 0xFFFFFFFF leaves LW 0x20 unchanged.
//  5. Drive req_valid during CLEAR -> no rsp_valid. Assert rst_n=0 at clear cycle 500:
//     clear restarts, 1024 full cycles before ready.
//  6. CLEAR_ON_RESET=0: req_ready=1 and init_done=1 first cycle after reset;
//     SW/LW round-trip 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM states and log2 helper for the data memory
package dmem_pkg;
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: byte-lane enables, store lane replication, misalign flag and load extension
//  size/lane/wdata -> be, wword, misalign ; size/is_unsigned/lane/rword -> rdata
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic        misalign,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    misalign = size == SIZE_ILL || (size == SIZE_H && lane[0]) || (size == SIZE_W && lane != 2'b00);
    be = size == SIZE_B ? 4'b0001 << lane : size == SIZE_H ? 4'b0011 << {lane[1], 1'b0} : size == SIZE_W ? 4'hf : 4'h0;
    // replicate narrow data across lanes so the byte enable alone picks the target lane
    wword = size == SIZE_B ? {4{wdata[7:0]}} : size == SIZE_H ? {2{wdata[15:0]}} : wdata;
    b = 8'(rword >> {lane, 3'b000});
    h = 16'(rword >> {lane[1], 4'b0000});
    rdata = size == SIZE_B ? {{24{~is_unsigned & b[7]}}, b} : size == SIZE_H ? {{16{~is_unsigned & h[15]}}, h} : rword;
  end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: clocked req/rsp data memory with byte lanes, range checks and post-reset clear
//  clk, rst_n (sync, active-low); req_* request in, req_ready out; rsp_* registered 1-cycle response; init_done
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);
  localparam int AW = log2(DEPTH);
  logic [31:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, idx;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, wword, ld;
  logic [3:0] be;
  logic misalign, range_err, err, acc;
  dmem_align u_align (
    .size(req_size), .lane(req_addr[1:0]), .wdata(req_wdata), .is_unsigned(req_unsigned),
    .rword(mem[idx]), .be(be), .wword(wword), .misalign(misalign), .rdata(ld)
  );
  assign idx = req_addr[AW+1:2];
  assign range_err = |(req_addr >> (AW + 2));
  assign err = misalign | range_err;
  assign req_ready = state_q == ST_READY;
  assign init_done = req_ready;
  assign acc = req_valid & req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == AW'(DEPTH - 1) ? ST_READY : ST_CLEAR;
    end
    rsp_valid_d = acc;
    rsp_err_d = acc ? err : rsp_err_q;
    rsp_rdata_d = acc ? (req_we | err ? 32'h0 : ld) : rsp_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_CLEAR) mem[cnt_q] <= '0;
      else if (acc & req_we & ~err)
        for (int k = 0; k < 4; k++) if (be[k]) mem[idx][8*k +: 8] <= wword[8*k +: 8];
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and random checks of data_memory_ctrl against a byte-array model
module tb_data_memory_ctrl;
  logic clk, rst_n, req_valid, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic req_ready, rsp_valid, rsp_err, init_done;
  logic b_rst_n, b_req_valid, b_req_we, b_req_unsigned;
  logic [1:0] b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic b_req_ready, b_rsp_valid, b_rsp_err, b_init_done;
  int n_checks, n_fail, cnt;
  logic [7:0] mb [4096];
  logic [31:0] last_rdata;
  logic last_err;

  data_memory_ctrl #(.DEPTH(1024), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );
  data_memory_ctrl #(.DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .init_done(b_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
    int n;
    n = 1 << sz;
    e = sz == 2'b11 || (a % n) != 0 || a >= 4096;
    rd = 0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd |= 32'(mb[a + i]) << (8 * i);
        if (!uns && n < 4 && rd[8*n-1]) rd |= ~((32'd1 << (8 * n)) - 1);
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    logic e;
    logic [31:0] rd;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    model(we, sz, uns, a, wd, e, rd);
    last_rdata = rd;
    last_err = e;
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(e));
    check("rsp_rdata", rsp_rdata, rd);
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom_range(0, 63);
    @(negedge clk);
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("hold_err", 32'(rsp_err), 32'(last_err));
    check("hold_rdata", rsp_rdata, last_rdata);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    foreach (mb[i]) mb[i] = 8'h00;
    last_rdata = 0; last_err = 1'b0;
    rst_n = 1'b0; b_rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 0; req_wdata = 0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b10; b_req_unsigned = 1'b0; b_req_addr = 0; b_req_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    // release, hammer requests during clear, then reset again at clear cycle 500
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = $urandom;
      check("clear_ready", 32'(req_ready), 32'd0);
      check("clear_drop", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      if (req_ready) begin
        req_valid = 1'b0;
        break;
      end
      cnt++;
      check("clear2_drop", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("clear_cycles", 32'(cnt), 32'd1024);
    check("init_done", 32'(init_done), 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h0FFC, 0);
    idle();
    // sign/zero extension
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 0);
    check("lb_13", last_rdata, 32'hFFFFFF88);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 0);
    check("lbu_13", last_rdata, 32'h00000088);
    issue(1'b0, 2'b01, 1'b0, 32'h10, 0);
    check("lh_10", last_rdata, 32'hFFFFAABB);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 0);
    check("lhu_12", last_rdata, 32'h00008899);
    // back-to-back partial stores then load
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000EE);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h00005566);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 0);
    check("lw_20_merge", last_rdata, 32'h5566EE44);
    idle();
    // errors
    issue(1'b0, 2'b10, 1'b0, 32'h22, 0);
    check("err_lw_22", 32'(last_err), 32'd1);
    issue(1'b0, 2'b01, 1'b0, 32'h23, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 0);
    check("lw_20_kept", last_rdata, 32'h5566EE44);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      a = sel == 0 ? 32'h1000 + $urandom_range(0, 15) : sel == 1 ? 32'h0FF8 + $urandom_range(0, 7) : $urandom_range(0, 63);
      if ($urandom_range(0, 4) == 0) idle();
      else issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    idle();
    // instance without clear
    @(negedge clk);
    b_rst_n = 1'b1;
    check("b_ready", 32'(b_req_ready), 32'd1);
    check("b_init_done", 32'(b_init_done), 32'd1);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'b10; b_req_addr = 32'h8; b_req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("b_sw_valid", 32'(b_rsp_valid), 32'd1);
    b_req_we = 1'b0; b_req_wdata = 0;
    @(negedge clk);
    check("b_lw_valid", 32'(b_rsp_valid), 32'd1);
    check("b_lw_rdata", b_rsp_rdata, 32'hDEADBEEF);
    check("b_lw_err", 32'(b_rsp_err), 32'd0);
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b_idle_valid", 32'(b_rsp_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
